pc_sequencer: RTL and testbench

- Program-counter sequencer that generates the 11-bit instruction address and drives the load enable of the downstream 11-bit address register.
- Supports increment, absolute jump, signed relative branch, call/return through a small return-address stack, and halt/resume.
- Sits between the control unit (command inputs) and the address register (consumes `pc` and `ar_enable`).

---
 rtl/pc_sequencer.sv | 155 +++++++++++++++
 tb/tb_pc_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer driving the instruction address and
// the load enable of the downstream address register.
// Optional feature macro: PCSEQ_CALL_STACK_EN (return-address stack, call/ret).
// With the macro undefined there is no stack, call acts as load and ret is ignored.
module pc_sequencer #(
  parameter int AW    = 11,
  parameter int DEPTH = 4,
  parameter int OFFW  = 8
) (
  input  logic            CLK,
  input  logic            clear,
  input  logic            inc,
  input  logic            load,
  input  logic            branch,
  input  logic            call,
  input  logic            ret,
  input  logic            halt,
  input  logic            resume,
  input  logic [AW-1:0]   target,
  input  logic [OFFW-1:0] offset,
  output logic [AW-1:0]   pc,
  output logic            ar_enable,
  output logic            halted,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            stack_err
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t        state;
  logic [AW-1:0] pc_nxt;
  logic          pc_wr;
  logic [AW-1:0] off_ext;

  // Offset is two's complement; AW is wider than OFFW.
  assign off_ext = {{(AW-OFFW){offset[OFFW-1]}}, offset};
  assign halted  = (state == HALTED);

`ifdef PCSEQ_CALL_STACK_EN
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = IW + 1;

  logic [CW-1:0] count;
  logic [AW-1:0] stack_mem [DEPTH];
  logic          push;
  logic          pop;
  logic          err_set;

  assign stack_empty = (count == '0);
  assign stack_full  = (count == CW'(DEPTH));

  // Select the single winning command for this cycle (ret > call > load > branch > inc).
  always_comb begin
    pc_nxt  = pc;
    pc_wr   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (state == RUN && !halt) begin
      if (ret) begin
        if (!stack_empty) begin
          pc_nxt = stack_mem[IW'(count - CW'(1))];
          pc_wr  = 1'b1;
          pop    = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end else if (call) begin
        if (!stack_full) begin
          pc_nxt = target;
          pc_wr  = 1'b1;
          push   = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end else if (load) begin
        pc_nxt = target;
        pc_wr  = 1'b1;
      end else if (branch) begin
        pc_nxt = pc + off_ext;
        pc_wr  = 1'b1;
      end else if (inc) begin
        pc_nxt = pc + AW'(1);
        pc_wr  = 1'b1;
      end
    end
  end

  // Return-address storage; contents above count are don't-care, so no reset.
  always_ff @(posedge CLK) begin
    if (!clear && push) begin
      stack_mem[IW'(count)] <= pc + AW'(1);
    end
  end

  // Stack occupancy and sticky error flag.
  always_ff @(posedge CLK) begin
    if (clear) begin
      count     <= '0;
      stack_err <= 1'b0;
    end else begin
      if (push)
        count <= count + CW'(1);
      else if (pop)
        count <= count - CW'(1);
      if (err_set)
        stack_err <= 1'b1;
    end
  end
`else
  logic unused_ret;

  assign unused_ret  = ret;
  assign stack_empty = 1'b1;
  assign stack_full  = 1'b0;
  assign stack_err   = 1'b0;

  // Select the single winning command (call acts as load, ret does not exist).
  always_comb begin
    pc_nxt = pc;
    pc_wr  = 1'b0;
    if (state == RUN && !halt) begin
      if (call || load) begin
        pc_nxt = target;
        pc_wr  = 1'b1;
      end else if (branch) begin
        pc_nxt = pc + off_ext;
        pc_wr  = 1'b1;
      end else if (inc) begin
        pc_nxt = pc + AW'(1);
        pc_wr  = 1'b1;
      end
    end
  end
`endif

  // RUN/HALTED state machine with registered pc and address-register enable.
  always_ff @(posedge CLK) begin
    if (clear) begin
      state     <= RUN;
      pc        <= '0;
      ar_enable <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      ar_enable <= pc_wr;
      case (state)
        RUN:     if (halt) state <= HALTED;
        HALTED:  if (resume && !halt) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand sequences
// for stack/halt corner cases, and randomized commands against a queue-based model.
module tb_pc_sequencer;

`ifdef PCSEQ_CALL_STACK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        clear, inc, load, branch, call, ret, halt, resume;
  logic [10:0] target;
  logic [7:0]  offset;
  logic [10:0] pc;
  logic        ar_enable, halted, stack_empty, stack_full, stack_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_halted, m_err, m_ar;

  pc_sequencer #(.AW(11), .DEPTH(DEPTH), .OFFW(8)) dut (
    .CLK(CLK), .clear(clear), .inc(inc), .load(load), .branch(branch),
    .call(call), .ret(ret), .halt(halt), .resume(resume), .target(target),
    .offset(offset), .pc(pc), .ar_enable(ar_enable), .halted(halted),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          clr, inc, ld, br, cl, rt, hl, rs;
    logic [10:0] tgt;
    logic [7:0]  off;
    logic [10:0] e_pc;
    bit          e_ar, e_hlt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one clock edge applied from the spec's rules.
  task automatic model_step();
    bit wr;
    int o;
    wr = 1'b0;
    if (clear) begin
      m_pc = 0; m_stk.delete(); m_halted = 0; m_err = 0;
    end else if (m_halted) begin
      if (resume && !halt) m_halted = 0;
    end else if (halt) begin
      m_halted = 1;
    end else if (EN && ret) begin
      if (m_stk.size() > 0) begin m_pc = m_stk.pop_back(); wr = 1; end
      else m_err = 1;
    end else if (call) begin
      if (!EN) begin m_pc = target; wr = 1; end
      else if (m_stk.size() < DEPTH) begin
        m_stk.push_back((m_pc + 1) & 'h7FF); m_pc = target; wr = 1;
      end else m_err = 1;
    end else if (load) begin
      m_pc = target; wr = 1;
    end else if (branch) begin
      o = offset;
      if (o >= 128) o -= 256;
      m_pc = (m_pc + o) & 'h7FF; wr = 1;
    end else if (inc) begin
      m_pc = (m_pc + 1) & 'h7FF; wr = 1;
    end
    m_ar = wr;
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("ar_enable", ar_enable, m_ar);
    check("halted", halted, m_halted);
    check("stack_empty", stack_empty, (m_stk.size() == 0) ? 1 : 0);
    check("stack_full", stack_full, (m_stk.size() == DEPTH) ? 1 : 0);
    check("stack_err", stack_err, m_err);
  endtask

  task automatic drive(input bit clr, i, ld, br, cl, rt, hl, rs,
                       input logic [10:0] tgt, input logic [7:0] off);
    clear = clr; inc = i; load = ld; branch = br; call = cl; ret = rt;
    halt = hl; resume = rs; target = tgt; offset = off;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic step(input bit clr, i, ld, br, cl, rt, hl, rs,
                      input logic [10:0] tgt, input logic [7:0] off);
    drive(clr, i, ld, br, cl, rt, hl, rs, tgt, off);
    tick();
  endtask

  function automatic vec_t mk(input bit clr, i, ld, br, cl, rt, hl, rs,
                              input logic [10:0] tgt, input logic [7:0] off,
                              input logic [10:0] e_pc, input bit e_ar, e_hlt);
    vec_t v;
    v.clr = clr; v.inc = i; v.ld = ld; v.br = br; v.cl = cl; v.rt = rt;
    v.hl = hl; v.rs = rs; v.tgt = tgt; v.off = off;
    v.e_pc = e_pc; v.e_ar = e_ar; v.e_hlt = e_hlt;
    return v;
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, '0, '0);

    //             clr i ld br cl rt hl rs  tgt     off     pc    ar h
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 11'h000, 8'h00, 11'h000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 11'h002, 8'h00, 11'h002, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 11'h000, 8'hFC, 11'h7FE, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 11'h000, 8'h05, 11'h003, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 11'h000, 8'h00, 11'h003, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 11'h003, 8'h00, 11'h003, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 11'h000, 8'h00, 11'h004, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 11'h000, 8'h00, 11'h004, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 11'h000, 8'h00, 11'h004, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 11'h000, 8'h00, 11'h004, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 11'h000, 8'h00, 11'h005, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 11'h200, 8'h01, 11'h200, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 11'h000, 8'h80, 11'h180, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 11'h7FF, 8'h00, 11'h7FF, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 11'h000, 8'h00, 11'h000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 11'h100, 8'h00, 11'h100, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 11'h055, 8'h00, 11'h000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 11'h000, 8'h00, 11'h000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 11'h000, 8'h00, 11'h000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 11'h000, 8'h00, 11'h000, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 11'h000, 8'h00, 11'h000, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 11'h000, 8'h00, 11'h000, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 11'h000, 8'h00, 11'h000, 0, 0));

    foreach (tbl[k]) begin
      step(tbl[k].clr, tbl[k].inc, tbl[k].ld, tbl[k].br, tbl[k].cl, tbl[k].rt,
           tbl[k].hl, tbl[k].rs, tbl[k].tgt, tbl[k].off);
      check($sformatf("tbl%0d_pc", k), pc, tbl[k].e_pc);
      check($sformatf("tbl%0d_ar", k), ar_enable, tbl[k].e_ar);
      check($sformatf("tbl%0d_halted", k), halted, tbl[k].e_hlt);
    end

    // Full wrap: 2048 increments from reset
    step(1, 0, 0, 0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 2048; i++) step(0, 1, 0, 0, 0, 0, 0, 0, '0, '0);
    check("wrap_pc", pc, 0);

    // Call/ret round trip
    step(0, 0, 1, 0, 0, 0, 0, 0, 11'h010, '0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 11'h100, '0);
    step(0, 0, 0, 0, 0, 1, 0, 0, '0, '0);

    // Overflow then underflow
    step(1, 0, 0, 0, 0, 0, 0, 0, '0, '0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 11'h010, '0);
    for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 1, 0, 0, 0, 11'(i * 'h100), '0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0, 0, '0, '0);
    step(0, 1, 0, 0, 0, 0, 0, 0, '0, '0);
    step(1, 0, 0, 0, 0, 0, 0, 0, '0, '0);

    // Halt with inc held, then resume
    step(0, 1, 0, 0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0, 1, 0, '0, '0);
    step(0, 1, 0, 0, 0, 0, 0, 1, '0, '0);
    step(0, 1, 0, 0, 0, 0, 0, 0, '0, '0);

    // Priority with a non-empty stack, then clear together with call
    step(0, 0, 0, 0, 1, 0, 0, 0, 11'h020, '0);
    step(0, 1, 1, 1, 1, 1, 0, 0, 11'h333, 8'h07);
    step(0, 0, 0, 0, 1, 0, 0, 0, 11'h040, '0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 11'h444, '0);

    // Randomized commands
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(63) == 0), $urandom_range(1), ($urandom_range(5) == 0),
           ($urandom_range(4) == 0), ($urandom_range(4) == 0), ($urandom_range(3) == 0),
           ($urandom_range(15) == 0), ($urandom_range(3) == 0),
           11'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
